// File: rtl/ws2812_loader.sv
// Byte-stream to pixel-buffer loader for the WS2812 driver: packs GRB bytes into 24-bit writes.
// Optional per-byte brightness scaling enabled by defining WS2812_LOADER_BRIGHTNESS_EN.
module ws2812_loader #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned TO_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic              sof,
`ifdef WS2812_LOADER_BRIGHTNESS_EN
  input  logic [7:0]        brightness,
`endif
  input  logic [11:0]       num_leds,
  output logic [ADDR_W-1:0] address,
  output logic [23:0]       rgb_data,
  output logic              write,
  output logic              frame_done,
  output logic              timeout_err
);

  localparam int unsigned PTR_W = 12;

  typedef enum logic {S_COLLECT, S_WRITE} state_t;

  state_t              state_q, state_d;
  logic [1:0]          phase_q, phase_d, phase_eff;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [TO_W-1:0]     cnt_q, cnt_d;
  logic [15:0]         pix_q, pix_d;
  logic                ready_q, ready_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [23:0]         rgb_q, rgb_d;
  logic                write_q, write_d;
  logic                terr_q, terr_d;
  logic                accept;
  logic                is_last;
  logic [7:0]          cap_byte;

  assign accept  = byte_valid && ready_q;
  assign is_last = (num_leds == 12'd0) || (ptr_q == (num_leds - 12'd1));

`ifdef WS2812_LOADER_BRIGHTNESS_EN
  // brightness+1 makes 255 an exact identity scale
  assign cap_byte = 8'((16'(byte_data) * (16'(brightness) + 16'd1)) >> 8);
`else
  assign cap_byte = byte_data;
`endif

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_COLLECT;
      phase_q <= 2'd0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      pix_q   <= '0;
      ready_q <= 1'b1;
      addr_q  <= '0;
      rgb_q   <= '0;
      write_q <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      pix_q   <= pix_d;
      ready_q <= ready_d;
      addr_q  <= addr_d;
      rgb_q   <= rgb_d;
      write_q <= write_d;
      terr_q  <= terr_d;
    end
  end

  // Next-state, packing, pointer and timeout logic
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    phase_eff = phase_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    pix_d     = pix_q;
    ready_d   = 1'b1;
    addr_d    = addr_q;
    rgb_d     = rgb_q;
    write_d   = 1'b0;
    terr_d    = 1'b0;

    case (state_q)
      S_COLLECT: begin
        // sof takes effect before a coincident byte, which becomes byte 0 of pixel 0
        if (sof) begin
          phase_eff = 2'd0;
          phase_d   = 2'd0;
          ptr_d     = '0;
          cnt_d     = '0;
        end
        if (accept) begin
          cnt_d = '0;
          case (phase_eff)
            2'd1: begin
              pix_d[7:0] = cap_byte;
              phase_d    = 2'd2;
            end
            2'd2: begin
              rgb_d   = {pix_q, cap_byte};
              addr_d  = ADDR_W'(ptr_q);
              phase_d = 2'd0;
              state_d = S_WRITE;
              write_d = 1'b1;
              ready_d = 1'b0;
            end
            default: begin
              pix_d[15:8] = cap_byte;
              phase_d     = 2'd1;
            end
          endcase
        end else if (!sof && (phase_q != 2'd0)) begin
          if (cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
            cnt_d   = '0;
            phase_d = 2'd0;
            terr_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + TO_W'(1);
          end
        end
      end

      S_WRITE: begin
        state_d = S_COLLECT;
        if (sof) begin
          cnt_d = '0;
        end
        if (sof || is_last) begin
          ptr_d = '0;
        end else begin
          ptr_d = ptr_q + PTR_W'(1);
        end
      end

      default: begin
        state_d = S_COLLECT;
        phase_d = 2'd0;
      end
    endcase
  end

  assign byte_ready  = ready_q;
  assign address     = addr_q;
  assign rgb_data    = rgb_q;
  assign write       = write_q;
  assign timeout_err = terr_q;
  // A sof landing on the write cycle restarts the frame, so the wrap is not a completion
  assign frame_done  = write_q && is_last && !sof;

endmodule

// File: tb/tb_ws2812_loader.sv
// Directed self-checking bench for ws2812_loader (brightness case under WS2812_LOADER_BRIGHTNESS_EN).
module tb_ws2812_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        sof;
  logic [11:0] num_leds;
  logic [7:0]  address;
  logic [23:0] rgb_data;
  logic        write;
  logic        frame_done;
  logic        timeout_err;
`ifdef WS2812_LOADER_BRIGHTNESS_EN
  logic [7:0]  brightness;
`endif

  ws2812_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .sof        (sof),
`ifdef WS2812_LOADER_BRIGHTNESS_EN
    .brightness (brightness),
`endif
    .num_leds   (num_leds),
    .address    (address),
    .rgb_data   (rgb_data),
    .write      (write),
    .frame_done (frame_done),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          terr_cnt = 0;
  int          ready_bad = 0;
  logic [7:0]  w_addr[$];
  logic [23:0] w_rgb[$];
  logic        w_fd[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Observe outputs mid-cycle
  always @(negedge clk) begin
    if (write) begin
      w_addr.push_back(address);
      w_rgb.push_back(rgb_data);
      w_fd.push_back(frame_done);
    end
    if (timeout_err) terr_cnt++;
    if (rst_n && (byte_ready == write)) ready_bad++;
  end

  task automatic clear_log();
    w_addr.delete();
    w_rgb.delete();
    w_fd.delete();
    terr_cnt = 0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one byte and hold it until accepted; returns 1 time unit after the accept edge
  task automatic send_byte(input logic [7:0] b);
    logic ok;
    int   n;
    byte_valid = 1'b1;
    byte_data  = b;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 8) begin
      @(negedge clk);
      ok = byte_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) chk("accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic send_px(input logic [23:0] px);
    send_byte(px[23:16]);
    send_byte(px[15:8]);
    send_byte(px[7:0]);
  endtask

  task automatic idle();
    byte_valid = 1'b0;
  endtask

  task automatic sof_pulse();
    sof = 1'b1;
    @(posedge clk);
    #1;
    sof = 1'b0;
  endtask

  int fd_sum;
  int n;

  initial begin
    rst_n      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    sof        = 1'b0;
    num_leds   = 12'd3;
`ifdef WS2812_LOADER_BRIGHTNESS_EN
    brightness = 8'd255;
`endif
    cycles(3);
    chk("rst_ready", 32'(byte_ready), 32'd1);
    chk("rst_write", 32'(write), 32'd0);
    rst_n = 1'b1;
    cycles(2);
    chk("rst_addr", 32'(address), 32'd0);
    chk("rst_rgb", rgb_data, 32'd0);
    chk("rst_fd_terr", {30'd0, frame_done, timeout_err}, 32'd0);

    // Back-to-back frame of three pixels
    clear_log();
    send_px(24'h112233);
    send_px(24'h445566);
    send_px(24'h778899);
    idle();
    cycles(4);
    chk("t1_nwrites", 32'(w_addr.size()), 32'd3);
    if (w_addr.size() == 3) begin
      chk("t1_a0", 32'(w_addr[0]), 32'd0);
      chk("t1_d0", w_rgb[0], 32'h112233);
      chk("t1_a1", 32'(w_addr[1]), 32'd1);
      chk("t1_d1", w_rgb[1], 32'h445566);
      chk("t1_a2", 32'(w_addr[2]), 32'd2);
      chk("t1_d2", w_rgb[2], 32'h778899);
      chk("t1_fd", {29'd0, w_fd[2], w_fd[1], w_fd[0]}, 32'b100);
    end
    chk("t1_ready_vs_write", 32'(ready_bad), 32'd0);

    // Wrap at num_leds=2
    clear_log();
    num_leds = 12'd2;
    send_px(24'h010203);
    send_px(24'h040506);
    send_px(24'h070809);
    send_px(24'h0A0B0C);
    idle();
    cycles(4);
    chk("t2_nwrites", 32'(w_addr.size()), 32'd4);
    if (w_addr.size() == 4) begin
      chk("t2_addrs", {w_addr[0], w_addr[1], w_addr[2], w_addr[3]}, 32'h00010001);
      chk("t2_d3", w_rgb[3], 32'h0A0B0C);
    end
    fd_sum = 0;
    foreach (w_fd[i]) fd_sum += int'(w_fd[i]);
    chk("t2_fd_count", 32'(fd_sum), 32'd2);

    // Partial pixel timeout
    clear_log();
    send_byte(8'hAA);
    send_byte(8'hBB);
    idle();
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (!timeout_err && n < 50100);
    chk("t3_to_latency", 32'(n), 32'd50000);
    cycles(3);
    chk("t3_terr_count", 32'(terr_cnt), 32'd1);
    chk("t3_no_write", 32'(w_addr.size()), 32'd0);
    send_px(24'hABCDEF);
    idle();
    cycles(3);
    chk("t3_nwrites", 32'(w_addr.size()), 32'd1);
    if (w_addr.size() == 1) begin
      chk("t3_addr", 32'(w_addr[0]), 32'd0);
      chk("t3_data", w_rgb[0], 32'hABCDEF);
    end

    // sof drops a partial pixel; sof coincident with a byte
    clear_log();
    num_leds = 12'd5;
    sof_pulse();
    send_px(24'hA1A2A3);
    send_px(24'hB1B2B3);
    send_byte(8'hC1);
    idle();
    cycles(2);
    sof_pulse();
    send_px(24'h010203);
    idle();
    cycles(3);
    chk("t4_nwrites", 32'(w_addr.size()), 32'd3);
    if (w_addr.size() == 3) begin
      chk("t4_addr1", 32'(w_addr[1]), 32'd1);
      chk("t4_addr2", 32'(w_addr[2]), 32'd0);
      chk("t4_data2", w_rgb[2], 32'h010203);
    end
    send_byte(8'h55);
    idle();
    cycles(1);
    sof = 1'b1;
    send_byte(8'h10);
    sof = 1'b0;
    send_byte(8'h20);
    send_byte(8'h30);
    idle();
    cycles(3);
    chk("t4b_nwrites", 32'(w_addr.size()), 32'd4);
    if (w_addr.size() == 4) begin
      chk("t4b_addr", 32'(w_addr[3]), 32'd0);
      chk("t4b_data", w_rgb[3], 32'h102030);
    end
    fd_sum = 0;
    foreach (w_fd[i]) fd_sum += int'(w_fd[i]);
    chk("t4_no_fd", 32'(fd_sum), 32'd0);
    chk("t4_no_terr", 32'(terr_cnt), 32'd0);

    // num_leds=0 acts as 1; sof on the write cycle suppresses frame_done and zeroes the pointer
    clear_log();
    num_leds = 12'd0;
    sof_pulse();
    send_px(24'h111111);
    idle();
    cycles(2);
    send_px(24'h222222);
    idle();
    sof_pulse();
    cycles(2);
    num_leds = 12'd3;
    send_px(24'h333333);
    send_px(24'h444444);
    idle();
    sof_pulse();
    cycles(2);
    send_px(24'h555555);
    idle();
    cycles(3);
    chk("t5_nwrites", 32'(w_addr.size()), 32'd5);
    if (w_addr.size() == 5) begin
      chk("t5_fd", {27'd0, w_fd[4], w_fd[3], w_fd[2], w_fd[1], w_fd[0]}, 32'b00001);
      chk("t5_addrs", {w_addr[1], w_addr[2], w_addr[3], w_addr[4]}, 32'h00000100);
    end

    // Reset right after the third byte suppresses the write
    clear_log();
    send_px(24'h999999);
    idle();
    rst_n = 1'b0;
    cycles(2);
    chk("t6_no_write", 32'(w_addr.size()), 32'd0);
    rst_n = 1'b1;
    cycles(2);
    chk("t6_ready", 32'(byte_ready), 32'd1);
    chk("t6_outs", {address, rgb_data}, 32'd0);
    send_px(24'h0C0D0E);
    idle();
    cycles(3);
    chk("t6_nwrites", 32'(w_addr.size()), 32'd1);
    if (w_addr.size() == 1) chk("t6_addr", 32'(w_addr[0]), 32'd0);

`ifdef WS2812_LOADER_BRIGHTNESS_EN
    clear_log();
    brightness = 8'd127;
    send_px(24'hFF8002);
    idle();
    cycles(3);
    chk("t7_nwrites", 32'(w_addr.size()), 32'd1);
    if (w_addr.size() == 1) chk("t7_scaled", w_rgb[0], 32'h7F4001);
`endif

    chk("ready_vs_write_all", 32'(ready_bad), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
